// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - client and divider signal bundle for div_share_arbiter
// DivByZero exists only when DIV_ZERO_BYPASS_EN is defined.
interface div_share_arbiter_if #(
    parameter int OPERAND_W = 8,
    parameter int N_REQ     = 4
);
    logic [N_REQ-1:0]           ReqIn;
    logic [N_REQ*OPERAND_W-1:0] DividendIn;
    logic [N_REQ*OPERAND_W-1:0] DivisorIn;
    logic [N_REQ-1:0]           Grant;
    logic [N_REQ-1:0]           RespDone;
    logic [OPERAND_W-1:0]       Quotient;
    logic [OPERAND_W-1:0]       Remainder;
`ifdef DIV_ZERO_BYPASS_EN
    logic                       DivByZero;
`endif
    logic                       Busy;
    logic                       DivReq;
    logic [OPERAND_W-1:0]       DivDividend;
    logic [OPERAND_W-1:0]       DivDivisor;
    logic                       DivDone;
    logic [OPERAND_W-1:0]       DivQuotient;
    logic [OPERAND_W-1:0]       DivRemainder;

    modport master (
`ifdef DIV_ZERO_BYPASS_EN
        input  DivByZero,
`endif
        output ReqIn,
        output DividendIn,
        output DivisorIn,
        input  Grant,
        input  RespDone,
        input  Quotient,
        input  Remainder,
        input  Busy,
        input  DivReq,
        input  DivDividend,
        input  DivDivisor,
        output DivDone,
        output DivQuotient,
        output DivRemainder
    );

    modport slave (
`ifdef DIV_ZERO_BYPASS_EN
        output DivByZero,
`endif
        input  ReqIn,
        input  DividendIn,
        input  DivisorIn,
        output Grant,
        output RespDone,
        output Quotient,
        output Remainder,
        output Busy,
        output DivReq,
        output DivDividend,
        output DivDivisor,
        input  DivDone,
        input  DivQuotient,
        input  DivRemainder
    );
endinterface

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin scheduler sharing one divider between N_REQ requesters
// Optional DIV_ZERO_BYPASS_EN answers zero divisors locally without using the divider.
module div_share_arbiter #(
    parameter int OPERAND_W = 8,
    parameter int N_REQ     = 4
) (
    input  logic               Clock,
    input  logic               nReset,
    div_share_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_gidx;
    logic [N_REQ-1:0]     r_grant;
    logic [N_REQ-1:0]     r_resp_done;
    logic                 r_div_req;
    logic [OPERAND_W-1:0] r_div_dividend;
    logic [OPERAND_W-1:0] r_div_divisor;
    logic [OPERAND_W-1:0] r_quotient;
    logic [OPERAND_W-1:0] r_remainder;
`ifdef DIV_ZERO_BYPASS_EN
    logic                 r_div_by_zero;
`endif

    logic                 w_found;
    logic [IDX_W-1:0]     w_sel;
    logic [N_REQ-1:0]     w_sel_onehot;
    logic [OPERAND_W-1:0] w_sel_dividend;
    logic [OPERAND_W-1:0] w_sel_divisor;
    logic [IDX_W-1:0]     w_ptr_next;
    logic                 w_load;
    logic                 w_bypass;
    logic                 w_capture;
    logic                 w_release;

    // First requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_found && bus.ReqIn[IDX_W'(v_idx)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_sel_dividend = bus.DividendIn[i*OPERAND_W +: OPERAND_W];
                w_sel_divisor  = bus.DivisorIn[i*OPERAND_W +: OPERAND_W];
            end
        end
    end

    assign w_sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
    assign w_ptr_next   = (r_gidx == IDX_W'(N_REQ-1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_bypass     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
`ifdef DIV_ZERO_BYPASS_EN
                    if (w_sel_divisor == '0) begin
                        w_bypass     = 1'b1;
                        w_next_state = RESPOND;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = ISSUE;
                    end
`else
                    w_load       = 1'b1;
                    w_next_state = ISSUE;
`endif
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                // DivDone is only meaningful here; stray pulses elsewhere are dropped.
                if (bus.DivDone) begin
                    w_capture    = 1'b1;
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                w_release    = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_ptr          <= '0;
            r_gidx         <= '0;
            r_grant        <= '0;
            r_resp_done    <= '0;
            r_div_req      <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_quotient     <= '0;
            r_remainder    <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_div_by_zero  <= 1'b0;
`endif
        end else begin
            r_div_req   <= w_load;
            r_resp_done <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_div_by_zero <= w_bypass;
`endif
            if (w_load || w_bypass) begin
                r_gidx  <= w_sel;
                r_grant <= w_sel_onehot;
            end
            // Operands are frozen here so requesters may change theirs mid-division.
            if (w_load) begin
                r_div_dividend <= w_sel_dividend;
                r_div_divisor  <= w_sel_divisor;
            end
            if (w_capture) begin
                r_quotient  <= bus.DivQuotient;
                r_remainder <= bus.DivRemainder;
                r_resp_done <= r_grant;
            end
            if (w_bypass) begin
                r_quotient  <= '1;
                r_remainder <= w_sel_dividend;
                r_resp_done <= w_sel_onehot;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    assign bus.Grant       = r_grant;
    assign bus.RespDone    = r_resp_done;
    assign bus.Quotient    = r_quotient;
    assign bus.Remainder   = r_remainder;
    assign bus.Busy        = (r_state != IDLE);
    assign bus.DivReq      = r_div_req;
    assign bus.DivDividend = r_div_dividend;
    assign bus.DivDivisor  = r_div_divisor;
`ifdef DIV_ZERO_BYPASS_EN
    assign bus.DivByZero   = r_div_by_zero;
`endif
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - randomized scoreboard bench for div_share_arbiter
module tb_div_share_arbiter;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int LAT = 9;

    typedef struct {
        int           idx;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    logic Clock = 1'b0;
    logic nReset;
    always #5 Clock = ~Clock;

    div_share_arbiter_if #(.OPERAND_W(W), .N_REQ(N)) bus ();
    div_share_arbiter #(.OPERAND_W(W), .N_REQ(N)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dreq_cnt = 0;
    int m_ptr    = 0;
    exp_t sb[$];
    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Divider model: Done pulses LAT cycles after Req; not reset, so a stale pulse can appear.
    initial begin
        int cnt;
        logic [W-1:0] la, lb;
        cnt = 0; la = '0; lb = '0;
        bus.DivDone = 1'b0; bus.DivQuotient = '0; bus.DivRemainder = '0;
        forever begin
            @(negedge Clock);
            bus.DivDone = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.DivDone      = 1'b1;
                    bus.DivQuotient  = (lb == 0) ? '1 : la / lb;
                    bus.DivRemainder = (lb == 0) ? la : la % lb;
                end
            end
            if (bus.DivReq === 1'b1) begin
                cnt = LAT; la = bus.DivDividend; lb = bus.DivDivisor; dreq_cnt++;
            end
        end
    end

    initial begin
        exp_t e;
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge Clock);
            if (nReset === 1'b1) begin
                chk("grant_onehot0", 32'($onehot0(bus.Grant)), 32'd1);
                if (bus.DivReq === 1'b1) begin
                    chk("divreq_single_cycle", 32'(prev_req), 32'd0);
                    chk("divreq_with_grant", 32'(bus.Busy && (bus.Grant != 0)), 32'd1);
                end
                if (bus.RespDone != 0) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'(bus.RespDone), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_done", 32'(bus.RespDone), 32'd1 << e.idx);
                        chk("grant_at_resp", 32'(bus.Grant), 32'd1 << e.idx);
                        chk("quotient", 32'(bus.Quotient), 32'(e.q));
                        chk("remainder", 32'(bus.Remainder), 32'(e.r));
                        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
`ifdef DIV_ZERO_BYPASS_EN
                        chk("div_by_zero", 32'(bus.DivByZero), 32'(e.dz));
`endif
                    end
                end
            end
            prev_req = bus.DivReq;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_grant", 32'(bus.Grant), 32'd0);
        chk("rst_resp_done", 32'(bus.RespDone), 32'd0);
        chk("rst_quotient", 32'(bus.Quotient), 32'd0);
        chk("rst_remainder", 32'(bus.Remainder), 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_divreq", 32'(bus.DivReq), 32'd0);
        chk("rst_div_dividend", 32'(bus.DivDividend), 32'd0);
        chk("rst_div_divisor", 32'(bus.DivDivisor), 32'd0);
`ifdef DIV_ZERO_BYPASS_EN
        chk("rst_div_by_zero", 32'(bus.DivByZero), 32'd0);
`endif
    endtask

    task automatic drive_operands();
        bus.DividendIn = {a_op[3], a_op[2], a_op[1], a_op[0]};
        bus.DivisorIn  = {b_op[3], b_op[2], b_op[1], b_op[0]};
    endtask

    // Raise mask at once while idle; expected service order is a rotation from the model pointer.
    task automatic run_round(input logic [N-1:0] mask, input int n_resp, input bit hold, input bit corrupt1);
        int t, t0, p, k, exp_dreq, dreq0, seen, budget;
        exp_t e;
        @(negedge Clock);
        drive_operands();
        bus.ReqIn = mask;
        t0 = cyc; t = cyc; p = m_ptr; k = 0; exp_dreq = 0; dreq0 = dreq_cnt;
        while (k < n_resp) begin
            if (((mask >> p) & 1) != 0) begin
                e.idx = p;
                e.dz  = (b_op[IW'(p)] == 0);
                if (e.dz) begin
                    e.q = '1; e.r = a_op[IW'(p)]; e.cyc = t + 1;
                end else begin
                    e.q = a_op[IW'(p)] / b_op[IW'(p)];
                    e.r = a_op[IW'(p)] % b_op[IW'(p)];
                    e.cyc = t + LAT + 2;
                    exp_dreq++;
                end
                sb.push_back(e);
                t = e.cyc + 1;
                k++;
                m_ptr = (p + 1) % N;
            end
            p = (p + 1) % N;
        end
        seen = 0; budget = 0;
        while (((bus.ReqIn != 0) || bus.Busy) && budget < 300) begin
            @(negedge Clock);
            budget++;
            if (corrupt1 && cyc == t0 + 5) begin
                bus.ReqIn[1] = 1'b0;
                bus.DividendIn[15:8] = 8'($urandom);
                bus.DivisorIn[15:8]  = 8'($urandom_range(1, 255));
            end
            if (bus.RespDone != 0) begin
                seen++;
                if (!hold) bus.ReqIn = bus.ReqIn & ~bus.RespDone;
                else if (seen >= n_resp) bus.ReqIn = '0;
            end
        end
        if (budget >= 300) begin
            checks++; failures++;
            $display("FAIL round_timeout actual=busy required=idle mask=%0h", mask);
            bus.ReqIn = '0;
        end
        chk("divreq_count", 32'(dreq_cnt - dreq0), 32'(exp_dreq));
    endtask

    initial begin
        logic [N-1:0] mask;
        nReset = 1'b0;
        bus.ReqIn = '0; bus.DividendIn = '0; bus.DivisorIn = '0;
        for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = 8'd1; end
        repeat (3) @(negedge Clock);
        check_reset_outputs();
        nReset = 1'b1;

        for (int i = 0; i < N; i++) begin
            a_op[i] = 8'($urandom); b_op[i] = 8'($urandom_range(1, 255));
        end
        run_round(4'hF, 5, 1'b1, 1'b0);

        a_op[2] = 8'd100; b_op[2] = 8'd7;
        run_round(4'b0100, 1, 1'b0, 1'b0);

        a_op[0] = 8'd200; b_op[0] = 8'd9; a_op[3] = 8'd77; b_op[3] = 8'd5;
        run_round(4'b1001, 2, 1'b0, 1'b0);

        a_op[1] = 8'd255; b_op[1] = 8'd16;
        run_round(4'b0010, 1, 1'b0, 1'b1);

`ifdef DIV_ZERO_BYPASS_EN
        a_op[0] = 8'd37; b_op[0] = 8'd0;
        run_round(4'b0001, 1, 1'b0, 1'b0);
`endif

        @(negedge Clock);
        a_op[0] = 8'd50; b_op[0] = 8'd3;
        drive_operands();
        bus.ReqIn = 4'b0001;
        repeat (4) @(negedge Clock);
        nReset = 1'b0;
        bus.ReqIn = '0;
        #1;
        check_reset_outputs();
        @(negedge Clock);
        nReset = 1'b1;
        m_ptr = 0;
        repeat (10) begin
            @(negedge Clock);
            chk("stale_busy", 32'(bus.Busy), 32'd0);
            chk("stale_resp", 32'(bus.RespDone), 32'd0);
        end
        chk("stale_quotient", 32'(bus.Quotient), 32'd0);
        a_op[0] = 8'd91; b_op[0] = 8'd4;
        run_round(4'b0001, 1, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                a_op[i] = 8'($urandom);
`ifdef DIV_ZERO_BYPASS_EN
                b_op[i] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
`else
                b_op[i] = 8'($urandom_range(1, 255));
`endif
            end
            run_round(mask, $countones(mask), 1'b0, 1'b0);
        end

        repeat (5) @(negedge Clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
